// File: rtl/decode_stage.sv
// decode_stage: buffered RV64I integer-ALU decode stage.
// A small circular queue absorbs fetch bursts. The queue head is decoded and
// loaded into a registered output stage that faces execute.
module decode_stage #(
    parameter int XLEN   = 64,
    parameter int QDEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      out_op,
    output logic [2:0]      out_alufunc,
    output logic            out_regwrite,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_src1_pc,
    output logic            out_src2_imm,
    output logic            out_illegal
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    localparam logic [3:0] OP_UNKNOWN = 4'd0, OP_ADDI = 4'd1, OP_XORI = 4'd2,
                           OP_ORI = 4'd3, OP_ANDI = 4'd4, OP_LUI = 4'd5,
                           OP_AUIPC = 4'd6, OP_ADD = 4'd7, OP_SUB = 4'd8,
                           OP_XOR = 4'd9, OP_OR = 4'd10, OP_AND = 4'd11;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_XOR = 3'd2,
                           ALU_OR = 3'd3, ALU_AND = 3'd4;

    logic [XLEN-1:0] pc_mem    [QDEPTH];
    logic [31:0]     instr_mem [QDEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;
    logic            valid_q;

    logic            push, pop;
    logic [31:0]     hd;

    logic [3:0]      op_d, op_q;
    logic [2:0]      alu_d, alu_q;
    logic            rw_d, rw_q;
    logic [4:0]      rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
    logic [XLEN-1:0] imm_d, imm_q, pc_q;
    logic            s1pc_d, s1pc_q, s2imm_d, s2imm_q, ill_d, ill_q;
    logic            legal;

    // No same-cycle pop bypass: readiness depends only on registered occupancy.
    assign in_ready = !reset && !flush && (count_q < CW'(QDEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count_q != '0) && (!valid_q || out_ready);
    assign hd       = instr_mem[head_q];

    // Decode the queue head; unsupported encodings collapse to an all-zero illegal record.
    always_comb begin
        op_d    = OP_UNKNOWN;
        alu_d   = ALU_ADD;
        rs1_d   = 5'd0;
        rs2_d   = 5'd0;
        rd_d    = hd[11:7];
        imm_d   = '0;
        s1pc_d  = 1'b0;
        s2imm_d = 1'b0;
        legal   = 1'b0;
        case (hd[6:0])
            7'b0010011: begin
                legal   = 1'b1;
                rs1_d   = hd[19:15];
                imm_d   = {{(XLEN-12){hd[31]}}, hd[31:20]};
                s2imm_d = 1'b1;
                case (hd[14:12])
                    3'b000:  begin op_d = OP_ADDI; alu_d = ALU_ADD; end
                    3'b100:  begin op_d = OP_XORI; alu_d = ALU_XOR; end
                    3'b110:  begin op_d = OP_ORI;  alu_d = ALU_OR;  end
                    3'b111:  begin op_d = OP_ANDI; alu_d = ALU_AND; end
                    default: legal = 1'b0;
                endcase
            end
            7'b0110011: begin
                legal = 1'b1;
                rs1_d = hd[19:15];
                rs2_d = hd[24:20];
                case ({hd[31:25], hd[14:12]})
                    {7'b0000000, 3'b000}: begin op_d = OP_ADD; alu_d = ALU_ADD; end
                    {7'b0100000, 3'b000}: begin op_d = OP_SUB; alu_d = ALU_SUB; end
                    {7'b0000000, 3'b100}: begin op_d = OP_XOR; alu_d = ALU_XOR; end
                    {7'b0000000, 3'b110}: begin op_d = OP_OR;  alu_d = ALU_OR;  end
                    {7'b0000000, 3'b111}: begin op_d = OP_AND; alu_d = ALU_AND; end
                    default: legal = 1'b0;
                endcase
            end
            7'b0110111, 7'b0010111: begin
                legal   = 1'b1;
                imm_d   = {{(XLEN-32){hd[31]}}, hd[31:12], 12'b0};
                s2imm_d = 1'b1;
                s1pc_d  = hd[5] ? 1'b0 : 1'b1;
                op_d    = hd[5] ? OP_LUI : OP_AUIPC;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            op_d    = OP_UNKNOWN;
            alu_d   = ALU_ADD;
            rs1_d   = 5'd0;
            rs2_d   = 5'd0;
            rd_d    = 5'd0;
            imm_d   = '0;
            s1pc_d  = 1'b0;
            s2imm_d = 1'b0;
        end
        rw_d  = legal && (rd_d != 5'd0);
        ill_d = !legal;
    end

    // Queue storage; push is already suppressed during reset and flush.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]    <= in_pc;
            instr_mem[tail_q] <= in_instr;
        end
    end

    // Queue pointers, occupancy and output-valid; reset and flush win over traffic.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
            if (pop)            valid_q <= 1'b1;
            else if (out_ready) valid_q <= 1'b0;
        end
    end

    // Output register: cleared on reset, loaded with the decoded head on pop, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= '0;
            op_q    <= '0;
            alu_q   <= '0;
            rw_q    <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            s1pc_q  <= 1'b0;
            s2imm_q <= 1'b0;
            ill_q   <= 1'b0;
        end else if (pop && !flush) begin
            pc_q    <= pc_mem[head_q];
            op_q    <= op_d;
            alu_q   <= alu_d;
            rw_q    <= rw_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            s1pc_q  <= s1pc_d;
            s2imm_q <= s2imm_d;
            ill_q   <= ill_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = pc_q;
    assign out_op       = op_q;
    assign out_alufunc  = alu_q;
    assign out_regwrite = rw_q;
    assign out_rs1      = rs1_q;
    assign out_rs2      = rs2_q;
    assign out_rd       = rd_q;
    assign out_imm      = imm_q;
    assign out_src1_pc  = s1pc_q;
    assign out_src2_imm = s2imm_q;
    assign out_illegal  = ill_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage with directed vectors.
module tb_decode_stage;
    typedef struct packed {
        logic [63:0] pc;
        logic [3:0]  op;
        logic [2:0]  alu;
        logic        rw;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic        s1pc;
        logic        s2imm;
        logic        ill;
    } dec_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc, out_pc, out_imm;
    logic [3:0]  out_op;
    logic [2:0]  out_alufunc;
    logic        out_regwrite, out_src1_pc, out_src2_imm, out_illegal;
    logic [4:0]  out_rs1, out_rs2, out_rd;

    int   checks = 0;
    int   errors = 0;
    dec_t sb[$];

    decode_stage #(.XLEN(64), .QDEPTH(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_op(out_op), .out_alufunc(out_alufunc), .out_regwrite(out_regwrite),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_src1_pc(out_src1_pc), .out_src2_imm(out_src2_imm),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    function automatic dec_t mk(input logic [63:0] pc, input int op, input int alu,
                                input int rw, input int rs1, input int rs2, input int rd,
                                input logic [63:0] imm, input int s1, input int s2,
                                input int ill);
        dec_t d;
        d.pc = pc; d.op = 4'(op); d.alu = 3'(alu); d.rw = 1'(rw);
        d.rs1 = 5'(rs1); d.rs2 = 5'(rs2); d.rd = 5'(rd); d.imm = imm;
        d.s1pc = 1'(s1); d.s2imm = 1'(s2); d.ill = 1'(ill);
        return d;
    endfunction

    function automatic dec_t dut_out();
        return {out_pc, out_op, out_alufunc, out_regwrite, out_rs1, out_rs2, out_rd,
                out_imm, out_src1_pc, out_src2_imm, out_illegal};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_dec(input string name, input dec_t act, input dec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output transfer is matched against the scoreboard head.
    initial begin : monitor
        dec_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1 && flush !== 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got pc %h, expected no transfer", out_pc);
                end else begin
                    e = sb.pop_front();
                    chk_dec("xfer", dut_out(), e);
                end
            end
        end
    end

    // One offer cycle: returns at posedge+1 with ok set if the edge accepted it.
    task automatic try_send(input logic [63:0] pc, input logic [31:0] ins, input dec_t e,
                            input bit rnd, output bit ok);
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = ins;
        @(negedge clk);
        ok = (in_ready === 1'b1);
        if (ok) sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] pc, input logic [31:0] ins, input dec_t e,
                        input bit rnd, output int tries);
        bit ok;
        ok = 1'b0;
        tries = 0;
        while (!ok && tries < 50) begin
            try_send(pc, ins, e, rnd, ok);
            tries++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: pc %h not accepted, expected acceptance", pc);
        end
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    logic [31:0] vin  [14];
    dec_t        vexp [14];

    initial begin : main
        int   tries, total, acc, k;
        bit   ok;
        dec_t bp_exp [5];
        logic [31:0] bp_in [5];
        dec_t snap;
        logic [11:0] im;

        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;

        vin[0]  = 32'hFFF00093; vexp[0]  = mk(64'h80000004, 1, 0, 1, 0, 0, 1, 64'hFFFFFFFFFFFFFFFF, 0, 1, 0);
        vin[1]  = 32'h80000137; vexp[1]  = mk(64'h80000008, 5, 0, 1, 0, 0, 2, 64'hFFFFFFFF80000000, 0, 1, 0);
        vin[2]  = 32'h00001097; vexp[2]  = mk(64'h8000000C, 6, 0, 1, 0, 0, 1, 64'h1000, 1, 1, 0);
        vin[3]  = 32'h402081B3; vexp[3]  = mk(64'h80000010, 8, 1, 1, 1, 2, 3, 64'h0, 0, 0, 0);
        vin[4]  = 32'h00000013; vexp[4]  = mk(64'h80000014, 1, 0, 0, 0, 0, 0, 64'h0, 0, 1, 0);
        vin[5]  = 32'h00000000; vexp[5]  = mk(64'h80000018, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 1);
        vin[6]  = 32'h0FF0C093; vexp[6]  = mk(64'h8000001C, 2, 2, 1, 1, 0, 1, 64'hFF, 0, 1, 0);
        vin[7]  = 32'h80036293; vexp[7]  = mk(64'h80000020, 3, 3, 1, 6, 0, 5, 64'hFFFFFFFFFFFFF800, 0, 1, 0);
        vin[8]  = 32'h7FF5F513; vexp[8]  = mk(64'h80000024, 4, 4, 1, 11, 0, 10, 64'h7FF, 0, 1, 0);
        vin[9]  = 32'h009473B3; vexp[9]  = mk(64'h80000028, 11, 4, 1, 8, 9, 7, 64'h0, 0, 0, 0);
        vin[10] = 32'h00E6E633; vexp[10] = mk(64'h8000002C, 10, 3, 1, 13, 14, 12, 64'h0, 0, 0, 0);
        vin[11] = 32'h0020C033; vexp[11] = mk(64'h80000030, 9, 2, 0, 1, 2, 0, 64'h0, 0, 0, 0);
        vin[12] = 32'h003100B3; vexp[12] = mk(64'h80000034, 7, 0, 1, 2, 3, 1, 64'h0, 0, 0, 0);
        vin[13] = 32'h4020C1B3; vexp[13] = mk(64'h80000038, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 1);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk_dec("rst_fields", dut_out(), '0);
        @(posedge clk); #1;
        reset = 1'b0;

        // First instruction and its two-cycle latency
        out_ready = 1'b1;
        send(64'h80000000, 32'h00500093,
             mk(64'h80000000, 1, 0, 1, 0, 0, 1, 64'd5, 0, 1, 0), 1'b0, tries);
        @(negedge clk);
        chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        // Directed decode vectors at full rate
        total = 0;
        for (int i = 0; i < 14; i++) begin
            send(vexp[i].pc, vin[i], vexp[i], 1'b0, tries);
            total += tries;
        end
        chk("throughput_tries", 64'(total), 64'd14);
        drain();
        @(negedge clk);
        chk("empty_valid_drop", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        // Back-pressure: capacity is queue plus output register
        for (int i = 0; i < 5; i++) begin
            bp_in[i]  = {12'(i + 10), 5'd0, 3'b000, 5'(i + 1), 7'h13};
            bp_exp[i] = mk(64'h2000 + 64'(4 * i), 1, 0, 1, 0, 0, i + 1, 64'(i + 10), 0, 1, 0);
        end
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            k = (acc < 5) ? acc : 4;
            try_send(bp_exp[k].pc, bp_in[k], bp_exp[k], 1'b0, ok);
            if (ok) acc++;
        end
        @(negedge clk);
        chk("bp_accepted", 64'(acc), 64'd3);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        snap = dut_out();
        chk_dec("bp_head", snap, bp_exp[0]);
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_dec("bp_stable", dut_out(), snap);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_drain_valid", 64'(out_valid), 64'd1);
        end
        chk("bp_in_ready_back", 64'(in_ready), 64'd1);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;

        // Flush with three buffered instructions
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(64'h3000 + 64'(4 * i), 32'h00100093,
                 mk(64'h3000 + 64'(4 * i), 1, 0, 1, 0, 0, 1, 64'd1, 0, 1, 0), 1'b0, tries);
        @(negedge clk);
        chk("pre_flush_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        flush = 1'b1;
        in_valid = 1'b1; in_pc = 64'h3FFC; in_instr = 32'h00200093;
        sb.delete();
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_valid", 64'(out_valid), 64'd0);
        chk("post_flush_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(64'h4000, 32'h00700113, mk(64'h4000, 1, 0, 1, 0, 0, 2, 64'd7, 0, 1, 0), 1'b0, tries);
        @(negedge clk);
        chk("flush_new_lat1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("flush_new_lat2", 64'(out_valid), 64'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Streaming with random back-pressure across pointer wrap-around
        for (int i = 0; i < 16; i++) begin
            im = 12'(i * 37);
            send(64'h5000 + 64'(4 * i), {im, 5'(i), 3'b000, 5'((i % 31) + 1), 7'h13},
                 mk(64'h5000 + 64'(4 * i), 1, 0, 1, i, 0, (i % 31) + 1, 64'(i * 37), 0, 1, 0),
                 1'b1, tries);
        end
        drain();
        repeat (2) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Buffered, parametrised instruction-decode stage for the pipelined RISC-V core. Accepts fetched {pc, instr} pairs over a valid/ready handshake into a QDEPTH-entry queue, decodes the queue head (RV64I integer ALU subset, immediate generation, illegal-instruction detection), and presents the result in an output register to execute over a second valid/ready handshake. Sits between fetch and execute. It supports flush and back-pressure in both directions.

## Interface
- XLEN, 64: datapath width; pc and immediate width.
- QDEPTH, 2: instruction queue entries; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch offers {in_pc, in_instr}.
- in_ready  out  1  queue can accept this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- flush  in  1  discard all buffered and output-register contents.
- out_valid  out  1  decoded instruction is presented.
- out_ready  in  1  execute accepts this cycle.
- out_pc  out  XLEN  pc of presented instruction.
- out_op  out  4  0 UNKNOWN, 1 ADDI, 2 XORI, 3 ORI, 4 ANDI, 5 LUI, 6 AUIPC, 7 ADD, 8 SUB, 9 XOR, 10 OR, 11 AND.
- out_alufunc  out  3  0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND.
- out_regwrite  out  1  writes rd.
- out_rs1, out_rs2, out_rd  out  5 each  register addresses.
- out_imm  out  XLEN  sign-extended immediate.
- out_src1_pc  out  1  ALU operand 1 is pc (AUIPC).
- out_src2_imm  out  1  ALU operand 2 is out_imm.
- out_illegal  out  1  instruction not in supported set.

## Operation
- Decode on opcode instr[6:0], funct3 instr[14:12], funct7 instr[31:25].
- 0010011: f3 000 ADDI, 100 XORI, 110 ORI, 111 ANDI; I-imm = sext(instr[31:20]); rs1 = instr[19:15], rs2 = 0; src2_imm 1.
- 0110011: f3 000 with f7 0000000 ADD, f7 0100000 SUB; f3 100/110/111 with f7 0000000 XOR/OR/AND; rs1, rs2 = instr[24:20]; imm 0; src2_imm 0.
- 0110111 LUI: imm = sext({instr[31:12], 12'b0}); rs1 = 0; alufunc ADD; src2_imm 1.
- 0010111 AUIPC: as LUI plus src1_pc 1.
- rd = instr[11:7] for all legal ops; regwrite = legal && rd != 0.
- Any other encoding: op 0, illegal 1, regwrite 0, alufunc 0, rs1 = rs2 = rd = 0, imm 0, src flags 0.
- Queue: circular buffer, head/tail pointers wrap modulo QDEPTH, count width $clog2(QDEPTH)+1.
- Push when in_valid && in_ready. Pop when count>0 && (!out_valid || out_ready). Push and pop in the same cycle are allowed.
- Output register loads the decode of the queue head on pop. If out_valid && out_ready and there is no pop, out_valid clears.
- in_ready = !reset && !flush && count < QDEPTH. It is combinational from state, with no same-cycle pop bypass.

## Timing
- Reset (edge with reset=1): count 0, pointers 0, out_valid 0, every out_* data field 0. in_ready is 0 while reset is high.
- Latency: an instruction accepted at the edge ending cycle N is in the queue in N+1 and on the outputs (out_valid 1) in N+2.
- Throughput: 1 instr/cycle sustained with out_ready held 1.
- Stall: while out_valid && !out_ready, all out_* are held bit-stable. The queue fills to QDEPTH and then in_ready drops.
- Full capacity: QDEPTH+1 instructions buffered (queue plus output register).
- Flush: at the flush edge, count 0, pointers 0, and out_valid 0 in the next cycle. in_valid is ignored in the flush cycle. The first post-flush accept follows normal latency.
- Flush and reset take priority over push, pop, and load in the same cycle.
- Empty queue with out_ready 1: out_valid drops to 0 the cycle after the last transfer.

## Test plan
- Reset, then push 0x00500093 (addi x1,x0,5) at pc 0x80000000 -> two cycles later: out_valid 1, op 1, rd 1, rs1 0, imm 5, regwrite 1, src2_imm 1, pc 0x80000000.
- Push 0xFFF00093 -> imm 0xFFFFFFFFFFFFFFFF. Push 0x80000137 (lui x2,0x80000) -> op 5, imm 0xFFFFFFFF80000000, rs1 0. Push 0x00001097 (auipc x1,1) -> op 6, src1_pc 1, imm 0x1000.
- Push 0x402081B3 (sub x3,x1,x2) -> op 8, alufunc 1, rs1 1, rs2 2, rd 3, src2_imm 0. Push 0x00000013 (nop) -> op 1, regwrite 0, illegal 0. Push 0x00000000 -> op 0, illegal 1, regwrite 0.
- Back-pressure (QDEPTH 2): out_ready 0, in_valid held 1 with 5 distinct instrs -> exactly 3 accepted, then in_ready 0. Outputs stay stable on the first instr. Raising out_ready -> all 3 emerge in order on consecutive cycles, and in_ready reasserts.
- Flush with 3 buffered and out_valid 1 -> next cycle out_valid 0, in_ready 1. A new instr pushed after the flush appears 2 cycles later, and no stale instr ever appears.
- Streaming 16 instrs with out_ready toggled randomly -> output order and pc match input order, and no drop or duplicate across pointer wrap-around.
